// File: rtl/shift_pkg.sv
// Shared encodings and per-stage control payload for the pipelined shift/rotate unit.
package shift_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] SH_LSL = 3'b000;
   localparam logic [MODE_W-1:0] SH_LSR = 3'b001;
   localparam logic [MODE_W-1:0] SH_ASR = 3'b010;
   localparam logic [MODE_W-1:0] SH_ROR = 3'b011;
   localparam logic [MODE_W-1:0] SH_ROL = 3'b100;

   // Control fields that ride alongside the data through every stage.
   typedef struct packed {
      logic [MODE_W-1:0] mode;
      logic              sign;
      logic              sat;
      logic              err;
   } shift_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel layer (shift by DIST when its amount bit is set) plus its pipeline register.
module shift_stage
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIST  = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic [WIDTH-1:0]         i_data,
   input  logic [$clog2(WIDTH)-1:0] i_amt,
   input  shift_ctrl_t              i_ctrl,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(WIDTH)-1:0] o_amt,
   output shift_ctrl_t              o_ctrl
);

   localparam int unsigned      L    = $clog2(WIDTH);
   localparam int unsigned      BIT  = $clog2(DIST);
   localparam bit               LAST = (DIST == WIDTH / 2);
   localparam logic [WIDTH-1:0] ONES = '1;

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [L-1:0]     r_amt;
   shift_ctrl_t      r_ctrl;

   logic [WIDTH-1:0] w_shr;
   logic [WIDTH-1:0] w_layer;
   logic [WIDTH-1:0] w_next;
   logic             w_load;

   // Layer shift; the last layer also folds in saturation for out-of-range amounts.
   always_comb begin
      w_shr   = i_data >> DIST;
      w_layer = i_data;
      if (i_amt[BIT]) begin
         case (i_ctrl.mode)
            SH_LSL:  w_layer = i_data << DIST;
            SH_LSR:  w_layer = w_shr;
            SH_ASR:  w_layer = w_shr | (i_ctrl.sign ? ~(ONES >> DIST) : '0);
            SH_ROR:  w_layer = w_shr | (i_data << (WIDTH - DIST));
            default: w_layer = i_data;
         endcase
      end
      w_next = w_layer;
      if (LAST && i_ctrl.sat) begin
         w_next = {WIDTH{i_ctrl.sign && (i_ctrl.mode == SH_ASR)}};
      end
   end

   // Accept when empty or when the downstream side takes our current op.
   assign w_load = !r_valid || i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_amt   <= '0;
         r_ctrl  <= '0;
      end else if (w_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= w_next;
            r_amt  <= i_amt;
            r_ctrl <= i_ctrl;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_amt   = r_amt;
   assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipelined_shifter.sv
// Fully pipelined LSL/LSR/ASR/ROR/ROL unit: one register per barrel layer, valid/ready on both sides.
module pipelined_shifter
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 8
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [WIDTH-1:0]  IN_DATA,
   input  logic [AMT_W-1:0]  IN_AMT,
   input  logic [MODE_W-1:0] IN_MODE,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [WIDTH-1:0]  OUT_DATA,
   output logic              OUT_ERR
);

   localparam int unsigned L = $clog2(WIDTH);

   logic             w_stg_valid [L];
   logic [WIDTH-1:0] w_stg_data  [L];
   logic [L-1:0]     w_stg_amt   [L];
   shift_ctrl_t      w_stg_ctrl  [L];
   logic [L:0]       w_ready;

   logic [L-1:0]     w_dec_amt;
   shift_ctrl_t      w_dec_ctrl;
   logic             w_unused_ok;

   // Input decode: ROL becomes ROR by the complementary amount; illegal modes pass data through.
   always_comb begin
      w_dec_ctrl      = '0;
      w_dec_ctrl.mode = IN_MODE;
      w_dec_ctrl.sign = IN_DATA[WIDTH-1];
      w_dec_amt       = IN_AMT[L-1:0];
      case (IN_MODE)
         SH_LSL, SH_LSR, SH_ASR: w_dec_ctrl.sat = (IN_AMT >= AMT_W'(WIDTH));
         SH_ROR:                 w_dec_ctrl.sat = 1'b0;
         SH_ROL: begin
            w_dec_ctrl.mode = SH_ROR;
            w_dec_amt       = L'(0) - IN_AMT[L-1:0];
         end
         default: begin
            w_dec_ctrl.err = 1'b1;
            w_dec_amt      = '0;
         end
      endcase
   end

   // Ready ripples back from the consumer through every stage (no skid buffer).
   always_comb begin
      w_ready    = '0;
      w_ready[L] = OUT_READY;
      for (int k = int'(L) - 1; k >= 0; k--) begin
         w_ready[k] = !w_stg_valid[k] || w_ready[k+1];
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_stage
      logic             w_in_valid;
      logic [WIDTH-1:0] w_in_data;
      logic [L-1:0]     w_in_amt;
      shift_ctrl_t      w_in_ctrl;

      if (k == 0) begin : g_first
         assign w_in_valid = IN_VALID;
         assign w_in_data  = IN_DATA;
         assign w_in_amt   = w_dec_amt;
         assign w_in_ctrl  = w_dec_ctrl;
      end else begin : g_chain
         assign w_in_valid = w_stg_valid[k-1];
         assign w_in_data  = w_stg_data[k-1];
         assign w_in_amt   = w_stg_amt[k-1];
         assign w_in_ctrl  = w_stg_ctrl[k-1];
      end

      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_stage (
         .i_clk   (CLK),
         .i_rst_n (RESET_N),
         .i_valid (w_in_valid),
         .i_data  (w_in_data),
         .i_amt   (w_in_amt),
         .i_ctrl  (w_in_ctrl),
         .i_ready (w_ready[k+1]),
         .o_valid (w_stg_valid[k]),
         .o_data  (w_stg_data[k]),
         .o_amt   (w_stg_amt[k]),
         .o_ctrl  (w_stg_ctrl[k])
      );
   end

   assign IN_READY  = w_ready[0];
   assign OUT_VALID = w_stg_valid[L-1];
   assign OUT_DATA  = w_stg_data[L-1];
   assign OUT_ERR   = w_stg_ctrl[L-1].err;

   assign w_unused_ok = ^{w_stg_amt[L-1], w_stg_ctrl[L-1].mode,
                          w_stg_ctrl[L-1].sign, w_stg_ctrl[L-1].sat};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench: directed spec cases, stalled stream, random traffic vs. arithmetic model, reset, WIDTH=32.
module tb_pipelined_shifter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_err;
   logic [7:0]  in_data, in_amt, out_data;
   logic [2:0]  in_mode;

   logic        v32, rdy32, ov32, err32;
   logic [31:0] d32, od32;
   logic [7:0]  a32;
   logic [2:0]  m32;

   int          vectors = 0;
   int          miscompares = 0;
   int          n_out = 0;
   logic [8:0]  exp_q[$];
   logic        hold_pending = 1'b0;
   logic [8:0]  hold_val = '0;
   logic        last_in_fire = 1'b0;

   pipelined_shifter #(.WIDTH(8), .AMT_W(8)) u_dut8 (
      .CLK(clk), .RESET_N(rst_n),
      .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_DATA(in_data), .IN_AMT(in_amt), .IN_MODE(in_mode),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_DATA(out_data), .OUT_ERR(out_err)
   );

   pipelined_shifter #(.WIDTH(32), .AMT_W(8)) u_dut32 (
      .CLK(clk), .RESET_N(rst_n),
      .IN_VALID(v32), .IN_READY(rdy32),
      .IN_DATA(d32), .IN_AMT(a32), .IN_MODE(m32),
      .OUT_VALID(ov32), .OUT_READY(1'b1),
      .OUT_DATA(od32), .OUT_ERR(err32)
   );

   // Reference result {err, data} for the 8-bit unit, straight from the mode definitions.
   function automatic logic [8:0] ref8(input logic [7:0] d, input logic [7:0] a, input logic [2:0] m);
      logic signed [7:0] sd;
      logic [15:0]       t;
      int                s;
      sd = d;
      s  = int'(a) % 8;
      case (m)
         3'd0: return {1'b0, (a >= 8'd8) ? 8'h00 : 8'(d << a)};
         3'd1: return {1'b0, (a >= 8'd8) ? 8'h00 : 8'(d >> a)};
         3'd2: return {1'b0, 8'(sd >>> ((a >= 8'd8) ? 7 : int'(a)))};
         3'd3: begin t = {d, d} >> s; return {1'b0, t[7:0]}; end
         3'd4: begin t = {d, d} << s; return {1'b0, t[15:8]}; end
         default: return {1'b1, d};
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample just after the falling edge, update the scoreboard, then advance one clock.
   task automatic tick();
      #1;
      if (hold_pending) begin
         check("stall_valid", 64'(out_valid), 64'(1));
         check("stall_hold", 64'({out_err, out_data}), 64'(hold_val));
      end
      hold_pending = out_valid && !out_ready;
      hold_val     = {out_err, out_data};
      last_in_fire = in_valid && in_ready;
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
         else check("scoreboard", 64'({out_err, out_data}), 64'(exp_q.pop_front()));
      end
      if (last_in_fire) exp_q.push_back(ref8(in_data, in_amt, in_mode));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic directed(input string tag, input logic [7:0] d, input logic [7:0] a,
                           input logic [2:0] m, input logic [7:0] exp_d, input logic exp_e);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_amt    = a;
      in_mode   = m;
      #1 check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(3));
      check({tag, "_data"}, 64'(out_data), 64'(exp_d));
      check({tag, "_err"}, 64'(out_err), 64'(exp_e));
      tick();
   endtask

   task automatic run32(input string tag, input logic [31:0] d, input logic [7:0] a,
                        input logic [2:0] m, input logic [31:0] exp_d);
      int lat;
      v32 = 1'b1;
      d32 = d;
      a32 = a;
      m32 = m;
      #1 check({tag, "_in_ready"}, 64'(rdy32), 64'(1));
      tick();
      v32 = 1'b0;
      lat = 1;
      while (!ov32 && lat < 12) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(5));
      check({tag, "_data"}, 64'(od32), 64'(exp_d));
      check({tag, "_err"}, 64'(err32), 64'(0));
      tick();
   endtask

   initial begin
      int sent;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      in_amt    = '0;
      in_mode   = '0;
      v32       = 1'b0;
      d32       = '0;
      a32       = '0;
      m32       = '0;

      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_out_data", 64'(out_data), 64'(0));
      check("reset_out_err", 64'(out_err), 64'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 check("reset_in_ready", 64'(in_ready), 64'(1));

      directed("lsl3",    8'h96, 8'd3,   3'b000, 8'hB0, 1'b0);
      directed("lsl8",    8'h96, 8'd8,   3'b000, 8'h00, 1'b0);
      directed("lsr200",  8'h96, 8'd200, 3'b001, 8'h00, 1'b0);
      directed("asr2",    8'h96, 8'd2,   3'b010, 8'hE5, 1'b0);
      directed("asr8",    8'h96, 8'd8,   3'b010, 8'hFF, 1'b0);
      directed("asr9pos", 8'h56, 8'd9,   3'b010, 8'h00, 1'b0);
      directed("ror3",    8'h96, 8'd3,   3'b011, 8'hD2, 1'b0);
      directed("ror11",   8'h96, 8'd11,  3'b011, 8'hD2, 1'b0);
      directed("rol3",    8'h96, 8'd3,   3'b100, 8'hB4, 1'b0);
      directed("rol0",    8'h96, 8'd0,   3'b100, 8'h96, 1'b0);
      directed("illegal", 8'h3C, 8'd5,   3'b110, 8'h3C, 1'b1);
      directed("legal_after_err", 8'h3C, 8'd0, 3'b000, 8'h3C, 1'b0);

      // Six mixed ops streamed while the consumer stalls in cycles 4..7.
      n_out   = 0;
      sent    = 0;
      in_data = 8'($urandom);
      in_amt  = 8'($urandom_range(0, 12));
      in_mode = 3'($urandom_range(0, 4));
      for (int c = 0; c < 40; c++) begin
         if (sent == 6 && exp_q.size() == 0 && !out_valid) break;
         out_ready = !(c >= 4 && c <= 7);
         in_valid  = (sent < 6);
         #1;
         if (c == 4) check("stream_in_ready_full", 64'(in_ready), 64'(0));
         if (c == 8) check("stream_in_ready_resume", 64'(in_ready), 64'(1));
         tick();
         if (last_in_fire) begin
            sent++;
            in_data = 8'($urandom);
            in_amt  = 8'($urandom_range(0, 12));
            in_mode = 3'($urandom_range(0, 4));
         end
      end
      in_valid = 1'b0;
      check("stream_count", 64'(n_out), 64'(6));
      check("stream_drained", 64'(exp_q.size()), 64'(0));

      // Random traffic with random backpressure, including illegal modes and large amounts.
      last_in_fire = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || last_in_fire) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            in_amt   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            in_mode  = 3'($urandom_range(0, 7));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
      check("random_drained", 64'(exp_q.size()), 64'(0));

      // Reset with two ops in flight and the consumer stalled.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      in_amt    = 8'd1;
      in_mode   = 3'b001;
      tick();
      in_data   = 8'h5A;
      tick();
      in_valid  = 1'b0;
      tick();
      check("rst_pre_valid", 64'(out_valid), 64'(1));
      hold_pending = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_err", 64'(out_err), 64'(0));
      exp_q.delete();
      tick();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1 check("rst_release_in_ready", 64'(in_ready), 64'(1));
      for (int c = 0; c < 5; c++) begin
         tick();
         check("rst_idle_valid", 64'(out_valid), 64'(0));
      end
      directed("post_reset", 8'h81, 8'd1, 3'b010, 8'hC0, 1'b0);

      run32("w32_lsl31", 32'h8000_0001, 8'd31, 3'b000, 32'h8000_0000);
      run32("w32_rol4",  32'h1234_5678, 8'd4,  3'b100, 32'h2345_6781);
      run32("w32_asr40", 32'h8000_0000, 8'd40, 3'b010, 32'hFFFF_FFFF);
      run32("w32_ror36", 32'h0000_00F1, 8'd36, 3'b011, 32'h1000_000F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
